// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit and receive halves.
//   UART_DATA_BITS    : data bits per frame (8N1 framing)
//   uart_state_e      : frame phase, common to both directions
//   bit_counter_width : width of a down-counter covering CLOCKS_PER_BIT cycles
// The PARITY phase is only entered when UART_TX_PARITY_EN is defined.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } uart_state_e;

  // A counter that only ever holds 0 still needs one bit.
  function automatic int unsigned bit_counter_width(int unsigned clocks_per_bit);
    return (clocks_per_bit < 2) ? 1 : $clog2(clocks_per_bit);
  endfunction

endpackage

// File: rtl/uart_transmitter_if.sv
// Byte handshake between upstream logic and the UART transmitter.
//   input_valid : upstream has a byte to send
//   input_data  : byte to send, sampled only on acceptance
//   input_ready : transmitter accepts a byte this cycle
// master = upstream producer, slave = transmitter.
interface uart_transmitter_if
  import uart_pkg::*;
;
  logic                      input_valid;
  logic [UART_DATA_BITS-1:0] input_data;
  logic                      input_ready;

  modport master (
    output input_valid,
    output input_data,
    input  input_ready
  );

  modport slave (
    input  input_valid,
    input  input_data,
    output input_ready
  );
endinterface

// File: rtl/uart_bit_timer.sv
// Down-counter that times one serial bit.
//   clock    : system clock, rising edge
//   reset    : synchronous, active-high
//   load     : reload with CLOCKS_PER_BIT-1 (wins over enable)
//   enable   : count down while the counter is above zero
//   bit_done : high in the last cycle of a bit (enable && count == 0)
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int unsigned CLOCKS_PER_BIT = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic enable,
  output logic bit_done
);

  localparam int unsigned CntWidth = bit_counter_width(CLOCKS_PER_BIT);
  localparam logic [CntWidth-1:0] Reload = CntWidth'(CLOCKS_PER_BIT - 1);

  logic [CntWidth-1:0] count_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= Reload;
    end else if (enable && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign bit_done = enable && (count_q == '0);

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: 8 data bits LSB first, 1 or 2 stop bits, idle-high line.
//   clock     : system clock, rising edge
//   reset     : synchronous, active-high; abandons any frame in progress
//   upstream  : valid/ready byte handshake (slave modport)
//   serial_tx : registered serial line
//   busy      : a frame is in progress
// Define UART_TX_PARITY_EN to add an even parity bit after the data bits.
// A byte may be accepted in the last stop cycle, so frames run back to back.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int unsigned CLOCKS_PER_BIT = 1,
  parameter int unsigned STOP_BITS      = 1
) (
  input  logic               clock,
  input  logic               reset,
  uart_transmitter_if.slave  upstream,
  output logic               serial_tx,
  output logic               busy
);

  uart_state_e               state_q, state_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0]                bit_idx_q, bit_idx_d;
  logic                      stop_idx_q, stop_idx_d;
  logic                      tx_q, tx_d;
  logic                      timer_load, timer_en, bit_done;
  logic                      last_stop, ready, accept;
`ifdef UART_TX_PARITY_EN
  logic                      parity_q;
`endif

  uart_bit_timer #(
    .CLOCKS_PER_BIT(CLOCKS_PER_BIT)
  ) u_bit_timer (
    .clock   (clock),
    .reset   (reset),
    .load    (timer_load),
    .enable  (timer_en),
    .bit_done(bit_done)
  );

  assign last_stop = (STOP_BITS == 1) || stop_idx_q;
  // Ready comes only from registered state, never from input_valid.
  assign ready     = (state_q == StIdle) || ((state_q == StStop) && bit_done && last_stop);
  assign accept    = upstream.input_valid && ready;

  assign upstream.input_ready = ready;
  assign serial_tx            = tx_q;
  assign busy                 = (state_q != StIdle);

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    timer_load = 1'b0;
    timer_en   = (state_q != StIdle);

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d    = StStart;
          shift_d    = upstream.input_data;
          bit_idx_d  = '0;
          stop_idx_d = 1'b0;
          timer_load = 1'b1;
        end
      end
      StStart: begin
        if (bit_done) begin
          state_d    = StData;
          timer_load = 1'b1;
        end
      end
      StData: begin
        if (bit_done) begin
          shift_d    = shift_q >> 1;
          bit_idx_d  = bit_idx_q + 3'd1;
          timer_load = 1'b1;
          if (bit_idx_q == 3'(UART_DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end
      end
      StParity: begin
        if (bit_done) begin
          state_d    = StStop;
          timer_load = 1'b1;
        end
      end
      StStop: begin
        if (bit_done) begin
          timer_load = 1'b1;
          if (last_stop) begin
            stop_idx_d = 1'b0;
            if (accept) begin
              state_d = StStart;
              shift_d = upstream.input_data;
            end else begin
              state_d = StIdle;
            end
          end else begin
            stop_idx_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Line is registered from the next state so it lines up with state_q and busy.
    unique case (state_d)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      StParity: tx_d = parity_q;
`else
      StParity: tx_d = 1'b1;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      tx_q       <= tx_d;
    end
  end

`ifdef UART_TX_PARITY_EN
  // Captured at acceptance so later input_data changes cannot alter it.
  always_ff @(posedge clock) begin
    if (reset) begin
      parity_q <= 1'b0;
    end else if (accept) begin
      parity_q <= ^upstream.input_data;
    end
  end
`endif

endmodule
